// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH-cycle latency.
// Define DIV_SIGNED_EN to add two's-complement (truncating) division selected by signed_op.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned REM_W = WIDTH + 1;
    localparam int unsigned RQ_W  = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [RQ_W-1:0]  rq;        // {partial remainder, quotient/dividend bits}
    logic [WIDTH-1:0] dvs_mag;
    logic [CNT_W-1:0] step_cnt;

    logic [RQ_W-1:0]  rq_shift_c;
    logic [REM_W-1:0] trial_c;
    logic [RQ_W-1:0]  rq_next_c;
    logic [WIDTH-1:0] q_mag_c;
    logic [WIDTH-1:0] r_mag_c;
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;
    logic [WIDTH-1:0] q_fin_c;
    logic [WIDTH-1:0] r_fin_c;
    logic             unused_bits;

    // One restoring step: shift, trial-subtract, keep or restore.
    assign rq_shift_c = {rq[RQ_W-2:0], 1'b0};
    assign trial_c    = rq_shift_c[RQ_W-1:WIDTH] - {1'b0, dvs_mag};
    assign rq_next_c  = trial_c[WIDTH] ? rq_shift_c
                                       : {trial_c, rq_shift_c[WIDTH-1:1], 1'b1};
    assign q_mag_c    = rq_next_c[WIDTH-1:0];
    assign r_mag_c    = rq_next_c[2*WIDTH-1:WIDTH];

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic dvd_neg_c;
    logic dvs_neg_c;

    assign dvd_neg_c   = signed_op & dividend[WIDTH-1];
    assign dvs_neg_c   = signed_op & divisor[WIDTH-1];
    assign dvd_mag_c   = dvd_neg_c ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag_c   = dvs_neg_c ? (~divisor + WIDTH'(1)) : divisor;
    // Remainder follows the dividend sign, so the result truncates toward zero.
    assign q_fin_c     = neg_q ? (~q_mag_c + WIDTH'(1)) : q_mag_c;
    assign r_fin_c     = neg_r ? (~r_mag_c + WIDTH'(1)) : r_mag_c;
    assign unused_bits = rq[RQ_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= dvd_neg_c ^ dvs_neg_c;
            neg_r <= dvd_neg_c;
        end
    end
`else
    assign dvd_mag_c   = dividend;
    assign dvs_mag_c   = divisor;
    assign q_fin_c     = q_mag_c;
    assign r_fin_c     = r_mag_c;
    assign unused_bits = rq[RQ_W-1] ^ signed_op;
`endif

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rq          <= '0;
            dvs_mag     <= '0;
            step_cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rq       <= {REM_W'(0), dvd_mag_c};
                        dvs_mag  <= dvs_mag_c;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rq       <= rq_next_c;
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (step_cnt == LAST_STEP) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= q_fin_c;
                        remainder   <= r_fin_c;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: transaction-level reference model checked every cycle,
// plus directed literal scenarios (latency, divide by zero, signed, ignored start, reset abort).
module tb_seq_divider;

    localparam int unsigned W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference division from plain arithmetic; returns {div_by_zero, quotient, remainder}.
    function automatic logic [64:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {1'b1, 32'hFFFF_FFFF, a};
        if (SIGNED_EN && s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    // Transaction model: an accepted start produces its result after a fixed latency.
    bit          m_active = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [64:0] m_pend = '0;
    logic [64:0] m_res = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_lat    <= 0;
            m_pend   <= '0;
            m_res    <= '0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_age + 1 == m_lat) begin
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
                if (m_age + 1 > m_lat) begin
                    m_active <= 1'b0;
                    m_busy   <= 1'b0;
                end
                m_age <= m_age + 1;
            end else if (start) begin
                m_active <= 1'b1;
                m_busy   <= 1'b1;
                m_age    <= 0;
                m_pend   <= ref_div(signed_op, dividend, divisor);
                m_lat    <= (divisor == '0) ? 0 : int'(W);
                if (divisor == '0) begin
                    m_done <= 1'b1;
                    m_res  <= ref_div(signed_op, dividend, divisor);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("busy", 65'(busy), 65'(m_busy));
            chk("done", 65'(done), 65'(m_done));
            chk("quotient", 65'(quotient), 65'(m_res[63:32]));
            chk("remainder", 65'(remainder), 65'(m_res[31:0]));
            chk("div_by_zero", 65'(div_by_zero), 65'(m_res[64]));
        end
    end

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 16));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one division from IDLE; report result, done latency (edges after sampling edge) and busy cycles.
    task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [64:0] res, output int lat, output int bcyc);
        int k;
        @(negedge clk);
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; signed_op = 1'($urandom); dividend = 32'($urandom); divisor = 32'($urandom);
        lat = -1; bcyc = 0; res = '0; k = 0;
        while (busy && k < 200) begin
            bcyc++;
            if (done && lat < 0) begin
                lat = k;
                res = {div_by_zero, quotient, remainder};
            end
            k++;
            @(negedge clk);
        end
        chk("op_ended", 65'(busy), 65'(0));
    endtask

    logic [64:0] res;
    int lat;
    int bcyc;
    int n_done;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 65'(busy), 65'(0));
        chk("rst_outs", {done, quotient, remainder[31:1]}, 65'(0));
        chk("rst_dbz", 65'(div_by_zero), 65'(0));
        rst_n = 1'b1;

        chk("model_100_7", ref_div(1'b0, 32'd100, 32'd7), {1'b0, 32'd14, 32'd2});
        chk("model_5_0", ref_div(1'b0, 32'd5, 32'd0), {1'b1, 32'hFFFF_FFFF, 32'd5});

        do_op(1'b0, 32'd100, 32'd7, res, lat, bcyc);
        chk("u100_7_res", res, {1'b0, 32'd14, 32'd2});
        chk("u100_7_lat", 65'(lat), 65'(32));
        chk("u100_7_busy", 65'(bcyc), 65'(33));

        do_op(1'b0, 32'd5, 32'd0, res, lat, bcyc);
        chk("div0_res", res, {1'b1, 32'hFFFF_FFFF, 32'd5});
        chk("div0_lat", 65'(lat), 65'(0));
        chk("div0_busy", 65'(bcyc), 65'(1));

        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, bcyc);
`ifdef DIV_SIGNED_EN
        chk("s_m7_2", res, {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
`else
        chk("s_m7_2", res, {1'b0, 32'h7FFF_FFFC, 32'd1});
`endif

        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcyc);
`ifdef DIV_SIGNED_EN
        chk("s_ovf", res, {1'b0, 32'h8000_0000, 32'd0});
`else
        chk("s_ovf", res, {1'b0, 32'd0, 32'h8000_0000});
`endif

        // Second start while busy must be dropped.
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        n_done = 0;
        for (int k = 1; k < 60; k++) begin
            start = (k == 10);
            dividend = 32'd9; divisor = 32'd3;
            if (done) begin
                n_done++;
                res = {div_by_zero, quotient, remainder};
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign_done_cnt", 65'(n_done), 65'(1));
        chk("ign_res", res, {1'b0, 32'd14, 32'd2});

        // Reset in the middle of RUN aborts without a done pulse.
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 65'(busy), 65'(0));
        chk("abort_res", {div_by_zero, quotient, remainder}, 65'(0));
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 65'(n_done), 65'(0));
        do_op(1'b0, 32'd9, 32'd3, res, lat, bcyc);
        chk("after_abort", res, {1'b0, 32'd3, 32'd0});

        // Random traffic, including starts while busy and rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            signed_op = 1'($urandom);
            dividend  = rnd_op();
            divisor   = rnd_op();
            rst_n     = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 4 to 64.
REQ-002 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 Port start, input, 1, request to begin a division; honoured only when busy=0.
REQ-005 Port signed_op, input, 1, operands are two's complement when 1; sampled with start.
REQ-006 Port dividend, input, WIDTH, numerator; sampled with start.
REQ-007 Port divisor, input, WIDTH, denominator; sampled with start.
REQ-008 Port busy, output, 1, high in every state except IDLE.
REQ-009 Port done, output, 1, one-cycle pulse; results are valid from this cycle.
REQ-010 Port quotient, output, WIDTH, registered quotient.
REQ-011 Port remainder, output, WIDTH, registered remainder.
REQ-012 Port div_by_zero, output, 1, registered flag: last accepted divisor was 0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; busy=1 in RUN and DONE.
REQ-014 In IDLE with start=1, the edge SHALL latch the operands and the mode, clear the step counter, and enter RUN; if divisor=0 it SHALL enter DONE instead.
REQ-015 RUN SHALL perform one restoring step per cycle on a 2*WIDTH+1-bit remainder/quotient register: shift left, trial-subtract the divisor magnitude with a WIDTH+1-bit subtractor, keep the difference and shift in 1 if it is non-negative, otherwise restore and shift in 0.
REQ-016 After exactly WIDTH RUN cycles the FSM SHALL enter DONE; done SHALL be high WIDTH edges after the start-sampling edge, and busy SHALL be high for WIDTH+1 cycles in total.
REQ-017 DONE SHALL last exactly one cycle, assert done, and update quotient, remainder and div_by_zero; the next edge SHALL return the FSM to IDLE.
REQ-018 Divisor=0 SHALL give done one cycle after start, with quotient all ones, remainder = dividend unmodified, and div_by_zero=1.
REQ-019 The quotient, remainder and div_by_zero outputs SHALL hold their values until the next DONE state; they SHALL NOT change during RUN.
REQ-020 start SHALL be ignored while busy=1, including in the DONE cycle; nothing is queued.
REQ-021 Operand changes after the start-sampling edge SHALL have no effect on the result.

Reset
REQ-022 rst_n low SHALL force IDLE asynchronously, including during RUN, which aborts the operation with no done pulse.
REQ-023 During reset, busy, done, quotient, remainder, div_by_zero and the step counter SHALL all be 0.

Configuration
REQ-024 Macro DIV_SIGNED_EN SHALL control signed support.
REQ-025 With DIV_SIGNED_EN defined and signed_op=1:
  - operands SHALL be converted to magnitudes at load;
  - the quotient SHALL be negated when the operand signs differ;
  - the remainder SHALL take the sign of the dividend (truncating division).
REQ-026 Signed overflow, the most-negative value divided by -1, SHALL give quotient = most-negative value and remainder 0, with no flag.
REQ-027 Without DIV_SIGNED_EN, signed_op SHALL be ignored, all operations SHALL be unsigned, and no sign-correction logic SHALL be present.

Verification (WIDTH=32)
REQ-028 Unsigned 100 / 7: busy high for 33 cycles and done 32 edges after start -> quotient 14, remainder 2, div_by_zero 0.
REQ-029 5 / 0: done one cycle after start -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1.
REQ-030 signed_op=1, 0xFFFFFFF9 / 2: with DIV_SIGNED_EN -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; without it -> quotient 0x7FFFFFFC, remainder 1.
REQ-031 With DIV_SIGNED_EN, signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-032 start 100/7, then start 9/3 pulsed 10 cycles later -> second start ignored; result 14 r 2 and only one done pulse.
REQ-033 rst_n pulsed low 10 cycles into RUN -> busy 0 and outputs 0 immediately, no done pulse; a new 9/3 after release -> quotient 3, remainder 0.
